alu_bist: RTL and testbench

Built-in self-test sequencer that drives the ALU's operand and control inputs and checks its outputs, so the hardware can exercise the ALU without an external bench. On `start` it generates a vector stream of fixed corner operands and then LFSR operands. It applies each vector under AND, OR, ADD and SUB, computes the expected result and zero flag internally, and counts mismatches. It sits beside the ALU in the execute stage and takes over the ALU inputs through an external mux while `busy` is high.

---
 rtl/alu_bist.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_bist.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// ALU built-in self-test: drives corner and LFSR operand vectors through AND/OR/ADD/SUB,
// checks result and zero flag against internally computed values, and records mismatches.
package alu_bist_pkg;
    localparam int RISC_V_DATA_WIDTH = 64;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } ALU_ctrl_t;
endpackage

module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int unsigned NUM_VECTORS   = 16,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [63:0] SEED          = 64'hACE1_0000_0000_0001
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [RISC_V_DATA_WIDTH-1:0] alu_data_in_A,
    output logic [RISC_V_DATA_WIDTH-1:0] alu_data_in_B,
    output ALU_ctrl_t                    alu_ctrl,
    input  logic [RISC_V_DATA_WIDTH-1:0] alu_data_out,
    input  logic                         alu_zero,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [15:0]                  fail_count,
    output logic                         first_fail_valid,
    output logic [15:0]                  first_fail_vec,
    output ALU_ctrl_t                    first_fail_op
);

    localparam logic [63:0] LFSR_TAPS   = 64'hD800_0000_0000_0000;
    localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Galois form of x^64+x^63+x^61+x^60+1, shifting toward bit 0.
    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        lfsr_step = {1'b0, s[63:1]} ^ (s[0] ? LFSR_TAPS : 64'd0);
    endfunction

    function automatic ALU_ctrl_t next_op(input ALU_ctrl_t op);
        case (op)
            ALU_AND: next_op = ALU_OR;
            ALU_OR:  next_op = ALU_ADD;
            ALU_ADD: next_op = ALU_SUB;
            default: next_op = ALU_AND;
        endcase
    endfunction

    function automatic logic [63:0] expected_result(input logic [63:0] a, input logic [63:0] b,
                                                    input ALU_ctrl_t op);
        case (op)
            ALU_AND: expected_result = a & b;
            ALU_OR:  expected_result = a | b;
            ALU_ADD: expected_result = a + b;
            ALU_SUB: expected_result = a - b;
            default: expected_result = 64'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [15:0] vec_q, vec_d;
    logic [63:0] a_q, a_d, b_q, b_d, lfsr_q, lfsr_d;
    ALU_ctrl_t   op_q, op_d, ff_op_q, ff_op_d;
    logic [3:0]  settle_q, settle_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0] fail_count_q, fail_count_d, ff_vec_q, ff_vec_d;
    logic        ff_valid_q, ff_valid_d;
    logic [63:0] exp_s, lfsr_1_s, lfsr_2_s;
    logic        mismatch_s, last_check_s;

    assign exp_s        = expected_result(a_q, b_q, op_q);
    assign mismatch_s   = (alu_data_out != exp_s) || (alu_zero != (exp_s == 64'd0));
    assign last_check_s = (vec_q == LAST_VEC) && (op_q == ALU_SUB);
    assign lfsr_1_s     = lfsr_step(lfsr_q);
    assign lfsr_2_s     = lfsr_step(lfsr_1_s);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_APPLY;
                else       state_d = state_q;
            end
            S_APPLY: begin
                if (settle_q == LAST_SETTLE) state_d = S_CHECK;
                else                         state_d = S_APPLY;
            end
            S_CHECK: begin
                if (last_check_s) state_d = S_DONE;
                else              state_d = S_APPLY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: vector generation, checking and result capture.
    always_comb begin
        vec_d        = vec_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        lfsr_d       = lfsr_q;
        settle_d     = settle_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        ff_valid_d   = ff_valid_q;
        ff_vec_d     = ff_vec_q;
        ff_op_d      = ff_op_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_d        = 16'd0;
                    a_d          = 64'd0;
                    b_d          = 64'd0;
                    op_d         = ALU_AND;
                    lfsr_d       = SEED;
                    settle_d     = 4'd0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_count_d = 16'd0;
                    ff_valid_d   = 1'b0;
                    ff_vec_d     = 16'd0;
                    ff_op_d      = ALU_AND;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_APPLY: begin
                if (settle_q == LAST_SETTLE) settle_d = 4'd0;
                else                         settle_d = settle_q + 4'd1;
            end
            S_CHECK: begin
                if (mismatch_s) begin
                    if (fail_count_q == 16'hFFFF) fail_count_d = fail_count_q;
                    else                          fail_count_d = fail_count_q + 16'd1;
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = vec_q;
                        ff_op_d    = op_q;
                    end else begin
                        ff_valid_d = 1'b1;
                    end
                end else begin
                    fail_count_d = fail_count_q;
                end
                if (last_check_s) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (fail_count_d == 16'd0);
                end else if (op_q == ALU_SUB) begin
                    vec_d = vec_q + 16'd1;
                    op_d  = ALU_AND;
                    // Vector 1 is the fixed all-ones/one pair; later vectors draw two LFSR steps.
                    if (vec_q == 16'd0) begin
                        a_d = 64'hFFFF_FFFF_FFFF_FFFF;
                        b_d = 64'd1;
                    end else begin
                        a_d    = lfsr_q;
                        b_d    = lfsr_1_s;
                        lfsr_d = lfsr_2_s;
                    end
                end else begin
                    op_d = next_op(op_q);
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q        <= 16'd0;
            a_q          <= 64'd0;
            b_q          <= 64'd0;
            op_q         <= ALU_AND;
            lfsr_q       <= SEED;
            settle_q     <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 16'd0;
            ff_valid_q   <= 1'b0;
            ff_vec_q     <= 16'd0;
            ff_op_q      <= ALU_AND;
        end else begin
            vec_q        <= vec_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            lfsr_q       <= lfsr_d;
            settle_q     <= settle_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            ff_valid_q   <= ff_valid_d;
            ff_vec_q     <= ff_vec_d;
            ff_op_q      <= ff_op_d;
        end
    end

    assign alu_data_in_A    = a_q;
    assign alu_data_in_B    = b_q;
    assign alu_ctrl         = op_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fail_count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_op    = ff_op_q;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a faultable ALU model beside the DUT and a scoreboard of
// expected vectors/ops pushed at each start and popped at each check window.
module tb_alu_bist;
    import alu_bist_pkg::*;

    localparam int NV      = 4;
    localparam int ST      = 2;
    localparam int CPC     = ST + 1;
    localparam int NCHK    = NV * 4;
    localparam int RUN_CYC = NCHK * CPC;
    localparam logic [63:0] SEED = 64'hACE1_0000_0000_0001;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        ALU_ctrl_t   op;
        logic [15:0] vec;
        logic        bad;
    } exp_t;

    logic        clk, rst, start;
    logic [63:0] alu_a, alu_b, alu_out;
    ALU_ctrl_t   alu_ctrl, ff_op;
    logic        alu_zero, busy, done, pass, ff_valid;
    logic [15:0] fail_count, ff_vec;

    int          fault_mode;
    int          n_pass, n_total, n_fail;
    exp_t        sb[$];
    logic [63:0] log_a[NCHK];
    logic [63:0] log_b[NCHK];
    ALU_ctrl_t   ops[4] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB};

    alu_bist #(.NUM_VECTORS(NV), .SETTLE_CYCLES(ST), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start),
        .alu_data_in_A(alu_a), .alu_data_in_B(alu_b), .alu_ctrl(alu_ctrl),
        .alu_data_out(alu_out), .alu_zero(alu_zero),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_valid(ff_valid), .first_fail_vec(ff_vec), .first_fail_op(ff_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model_res(input logic [63:0] a, input logic [63:0] b,
                                              input ALU_ctrl_t op);
        case (op)
            ALU_AND: model_res = a & b;
            ALU_OR:  model_res = a | b;
            ALU_ADD: model_res = a + b;
            ALU_SUB: model_res = a - b;
            default: model_res = 64'd0;
        endcase
    endfunction

    // Bitwise form of the feedback: output bit 0 re-enters at bits 63, 62, 60, 59.
    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        logic [63:0] n;
        n      = s >> 1;
        n[63]  = s[0];
        n[62]  = s[63] ^ s[0];
        n[60]  = s[61] ^ s[0];
        n[59]  = s[60] ^ s[0];
        return n;
    endfunction

    // ALU model with selectable faults.
    always_comb begin
        logic [63:0] r;
        r        = model_res(alu_a, alu_b, alu_ctrl);
        alu_out  = r;
        alu_zero = (r == 64'd0);
        case (fault_mode)
            1: if (alu_ctrl == ALU_ADD && alu_a == 64'hFFFF_FFFF_FFFF_FFFF && alu_b == 64'd1) begin
                   alu_out  = r + 64'd1;
                   alu_zero = 1'b0;
               end
            2: alu_zero = 1'b0;
            3: begin
                   alu_out  = ~r;
                   alu_zero = (~r == 64'd0);
               end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input int mode);
        logic [63:0] s, a, b, r;
        exp_t e;
        s = SEED;
        for (int v = 0; v < NV; v++) begin
            if (v == 0) begin
                a = 64'd0; b = 64'd0;
            end else if (v == 1) begin
                a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1;
            end else begin
                a = s; s = lfsr_next(s); b = s; s = lfsr_next(s);
            end
            for (int o = 0; o < 4; o++) begin
                r     = model_res(a, b, ops[o]);
                e.a   = a;
                e.b   = b;
                e.op  = ops[o];
                e.vec = 16'(v);
                case (mode)
                    1:       e.bad = (ops[o] == ALU_ADD) && (v == 1);
                    2:       e.bad = (r == 64'd0);
                    3:       e.bad = 1'b1;
                    default: e.bad = 1'b0;
                endcase
                sb.push_back(e);
            end
        end
    endtask

    // One full run; log_mode 1 records operands, 2 compares against the recording.
    task automatic run(input int mode, input int ignore_at, input bit sat, input int log_mode);
        exp_t        e;
        int          j;
        logic [15:0] exp_fc, exp_vec;
        logic        exp_ffv;
        ALU_ctrl_t   exp_op;
        fault_mode = mode;
        exp_fc = 16'd0; exp_ffv = 1'b0; exp_vec = 16'd0; exp_op = ALU_AND;
        sb.delete();
        push_run(mode);
        @(negedge clk) start = 1'b1;
        for (int cyc = 0; cyc < RUN_CYC; cyc++) begin
            @(negedge clk);
            start = (cyc == ignore_at);
            check("busy_in_run", 64'(busy), 64'd1);
            if (sat && cyc == 4) force dut.fail_count_q = 16'hFFFD;
            if (sat && cyc == 7) release dut.fail_count_q;
            if (cyc == 0) begin
                check("done_cleared", 64'(done), 64'd0);
                check("pass_cleared", 64'(pass), 64'd0);
                check("ffv_cleared", 64'(ff_valid), 64'd0);
            end
            if (cyc % CPC == 0) begin
                j = cyc / CPC;
                if (sb.size() == 0) begin
                    check("sb_empty", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("alu_A", alu_a, e.a);
                    check("alu_B", alu_b, e.b);
                    check("alu_op", 64'(alu_ctrl), 64'(e.op));
                    if (!sat || j < 2)  check("fail_count_run", 64'(fail_count), 64'(exp_fc));
                    else if (j >= 6)    check("fail_count_sat", 64'(fail_count), 64'hFFFF);
                    if (log_mode == 1) begin
                        log_a[j] = alu_a; log_b[j] = alu_b;
                    end else if (log_mode == 2) begin
                        check("rerun_A", alu_a, log_a[j]);
                        check("rerun_B", alu_b, log_b[j]);
                    end
                    if (e.bad) begin
                        if (exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
                        if (!exp_ffv) begin
                            exp_ffv = 1'b1; exp_vec = e.vec; exp_op = e.op;
                        end
                    end
                end
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("busy_end", 64'(busy), 64'd0);
        check("done_end", 64'(done), 64'd1);
        check("pass_end", 64'(pass), 64'(exp_fc == 16'd0 && !sat));
        if (sat) check("fail_count_end", 64'(fail_count), 64'hFFFF);
        else     check("fail_count_end", 64'(fail_count), 64'(exp_fc));
        check("ffv_end", 64'(ff_valid), 64'(exp_ffv));
        check("ffvec_end", 64'(ff_vec), 64'(exp_vec));
        check("ffop_end", 64'(ff_op), 64'(exp_op));
        repeat (3) @(negedge clk);
        check("done_held", 64'(done), 64'd1);
        check("alu_op_held", 64'(alu_ctrl), 64'(ALU_SUB));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_fc"}, 64'(fail_count), 64'd0);
        check({tag, "_ffv"}, 64'(ff_valid), 64'd0);
        check({tag, "_ffvec"}, 64'(ff_vec), 64'd0);
        check({tag, "_ffop"}, 64'(ff_op), 64'(ALU_AND));
        check({tag, "_A"}, alu_a, 64'd0);
        check({tag, "_B"}, alu_b, 64'd0);
        check({tag, "_op"}, 64'(alu_ctrl), 64'(ALU_AND));
    endtask

    initial begin
        n_pass = 0; n_total = 0; n_fail = 0;
        fault_mode = 0;
        rst = 1'b1;
        start = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Clean run, recording operands; vector 2 B is the first LFSR step from SEED.
        run(0, -1, 1'b0, 1);
        check("lfsr_v2_A", log_a[8], SEED);
        check("lfsr_v2_B", log_b[8], 64'h8E70_8000_0000_0000);
        check("clean_pass", 64'(pass), 64'd1);

        // Restart from DONE with a start pulse during the run that must be ignored.
        run(0, 5, 1'b0, 2);

        // Data fault on vector 1 ADD only.
        run(1, -1, 1'b0, 0);
        check("data_fc", 64'(fail_count), 64'd1);
        check("data_vec", 64'(ff_vec), 64'd1);
        check("data_op", 64'(ff_op), 64'(ALU_ADD));
        check("data_pass", 64'(pass), 64'd0);

        // Zero flag stuck at 0.
        run(2, -1, 1'b0, 0);
        check("zero_fc", 64'(fail_count), 64'd5);
        check("zero_vec", 64'(ff_vec), 64'd0);
        check("zero_op", 64'(ff_op), 64'(ALU_AND));

        // Every check fails; counter preloaded near the top must saturate, not wrap.
        run(3, -1, 1'b1, 0);

        // Reset in the middle of vector 3 ADD with failures already counted.
        fault_mode = 3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (14 * CPC) @(negedge clk);
        check("mid_op", 64'(alu_ctrl), 64'(ALU_ADD));
        check("mid_fc", 64'(fail_count), 64'd14);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);

        // A fresh start after reset behaves as a normal clean run.
        run(0, -1, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
